// File: rtl/bist_pkg.sv
// Shared types and constants for the adder BIST sequencer.
package bist_pkg;

  // Operand width of the adder under test and of K.
  localparam int DATA_WIDTH = 6;

  // Last operand A value of a sweep.
  localparam int A_MAX = (1 << DATA_WIDTH) - 1;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    REQ_K,
    WAIT_K,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } bist_state_e;

endpackage

// File: rtl/adder_bist_ctrl_if.sv
// K-generator handshake and adder-under-test operand/result bus.
interface adder_bist_ctrl_if #(
  parameter int DATA_WIDTH = bist_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] k_i;
  logic                  k_valid_i;
  logic                  k_last_i;
  logic                  k_req_o;
  logic [DATA_WIDTH-1:0] dut_a_o;
  logic [DATA_WIDTH-1:0] dut_b_o;
  logic [DATA_WIDTH:0]   dut_sum_i;

  // Sequencer side.
  modport master (
    input  k_i, k_valid_i, k_last_i, dut_sum_i,
    output k_req_o, dut_a_o, dut_b_o
  );

  // K-generator / adder side.
  modport slave (
    output k_i, k_valid_i, k_last_i, dut_sum_i,
    input  k_req_o, dut_a_o, dut_b_o
  );
endinterface

// File: rtl/bist_settle_timer.sv
// Loadable down-counter that flags when the settle window has elapsed.
module bist_settle_timer #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Loaded with CYCLES-1 so the counter reads zero on the last settle cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Load on APPLY, count down during SETTLE, hold at zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/adder_bist_ctrl.sv
// Adder BIST sequencer: fetches each K, sweeps A over the full range,
// checks the adder sum and records the error count and first failure.
module adder_bist_ctrl #(
  parameter int DATA_WIDTH    = bist_pkg::DATA_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  adder_bist_ctrl_if.master        bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [DATA_WIDTH-1:0]    first_err_a_o,
  output logic [DATA_WIDTH-1:0]    first_err_b_o,
  output logic [DATA_WIDTH:0]      first_err_sum_o
);
  import bist_pkg::*;

  localparam logic [DATA_WIDTH-1:0] A_LAST = {DATA_WIDTH{1'b1}};

  bist_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]    a_q, b_q;
  logic [ERR_CNT_WIDTH-1:0] err_q;
  logic                     first_seen_q;
  logic [DATA_WIDTH-1:0]    first_a_q, first_b_q;
  logic [DATA_WIDTH:0]      first_sum_q;
  logic                     settle_done;
  logic [DATA_WIDTH:0]      expected_sum;
  logic                     mismatch;

  // Full-width expected sum keeps the carry-out under test.
  assign expected_sum = {1'b0, a_q} + {1'b0, b_q};
  assign mismatch     = (bus.dut_sum_i != expected_sum);

  bist_settle_timer #(
    .CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk (clk),
    .rst (rst),
    .load(state_q == APPLY),
    .en  (state_q == SETTLE),
    .zero(settle_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_i) state_d = REQ_K;
      REQ_K:      state_d = WAIT_K;
      WAIT_K: begin
        if (bus.k_last_i)       state_d = DONE;
        else if (bus.k_valid_i) state_d = APPLY;
      end
      APPLY:      state_d = SETTLE;
      SETTLE:     if (settle_done) state_d = CHECK;
      CHECK:      state_d = (a_q == A_LAST) ? REQ_K : APPLY;
      default:    state_d = IDLE;
    endcase
  end

  // Operand registers, error counter and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      err_q        <= '0;
      first_seen_q <= 1'b0;
      first_a_q    <= '0;
      first_b_q    <= '0;
      first_sum_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            err_q        <= '0;
            first_seen_q <= 1'b0;
            first_a_q    <= '0;
            first_b_q    <= '0;
            first_sum_q  <= '0;
          end
        end
        WAIT_K: begin
          if (!bus.k_last_i && bus.k_valid_i) begin
            b_q <= bus.k_i;
            a_q <= '0;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_q != {ERR_CNT_WIDTH{1'b1}}) err_q <= err_q + 1'b1;
            if (!first_seen_q) begin
              first_seen_q <= 1'b1;
              first_a_q    <= a_q;
              first_b_q    <= b_q;
              first_sum_q  <= bus.dut_sum_i;
            end
          end
          // A is left at its last value after the sweep; the next K reloads it.
          if (a_q != A_LAST) a_q <= a_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.k_req_o     = (state_q == REQ_K);
  assign bus.dut_a_o     = a_q;
  assign bus.dut_b_o     = b_q;
  assign busy_o          = (state_q != IDLE) && (state_q != DONE);
  assign done_o          = (state_q == DONE);
  assign pass_o          = (state_q == DONE) && (err_q == '0);
  assign err_count_o     = err_q;
  assign first_err_a_o   = first_a_q;
  assign first_err_b_o   = first_b_q;
  assign first_err_sum_o = first_sum_q;
endmodule
